// File: rtl/counter_sequencer.sv
// Command-driven sequencer for a WIDTH-bit up-counter: START/STOP/RESUME/ABORT, one-shot or periodic.
// Optional prescaler enabled by defining CNT_SEQ_PRESCALE_EN (one tick every PRESCALE cycles).
module counter_sequencer #(
  parameter int WIDTH    = 5,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_limit,
  input  logic             cmd_periodic,
  output logic [WIDTH-1:0] counter,
  output logic             busy,
  output logic             paused,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    OP_START  = 2'b00,
    OP_STOP   = 2'b01,
    OP_RESUME = 2'b10,
    OP_ABORT  = 2'b11
  } op_e;

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("counter_sequencer: PRESCALE must be >= 1");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] counter_q, counter_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             periodic_q, periodic_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             accept;
  logic             tick;
  op_e              op;

  assign accept = cmd_valid && ready_q;
  assign op     = op_e'(cmd_op);

`ifdef CNT_SEQ_PRESCALE_EN
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0] presc_q, presc_d;
  logic            presc_wrap;

  assign presc_wrap = (presc_q == PS_W'(PRESCALE - 1));
  assign tick       = (state_q == ST_RUN) && presc_wrap;

  // STOP keeps the phase; PAUSE freezes it; START/RESUME/ABORT realign it.
  always_comb begin
    presc_d = presc_q;
    if (accept) begin
      if (op != OP_STOP) presc_d = '0;
    end else if (state_q == ST_RUN) begin
      presc_d = presc_wrap ? '0 : presc_q + PS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) presc_q <= '0;
    else        presc_q <= presc_d;
  end
`else
  assign tick = (state_q == ST_RUN);
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    limit_d    = limit_q;
    periodic_d = periodic_q;
    done_d     = 1'b0;
    ready_d    = !accept;

    // An accepted command always wins over a same-cycle tick.
    if (accept) begin
      case (op)
        OP_START: begin
          state_d    = ST_RUN;
          counter_d  = '0;
          limit_d    = cmd_limit;
          periodic_d = cmd_periodic;
        end
        OP_STOP:   if (state_q == ST_RUN)   state_d = ST_PAUSE;
        OP_RESUME: if (state_q == ST_PAUSE) state_d = ST_RUN;
        OP_ABORT: begin
          state_d   = ST_IDLE;
          counter_d = '0;
        end
      endcase
    end else if (tick) begin
      if (counter_q == limit_q) begin
        done_d = 1'b1;
        if (periodic_q) counter_d = '0;
        else            state_d   = ST_IDLE;
      end else begin
        counter_d = counter_q + WIDTH'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      counter_q  <= '0;
      limit_q    <= '0;
      periodic_q <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      limit_q    <= limit_d;
      periodic_q <= periodic_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
    end
  end

  assign cmd_ready = ready_q;
  assign counter   = counter_q;
  assign done      = done_q;
  assign busy      = (state_q != ST_IDLE);
  assign paused    = (state_q == ST_PAUSE);

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer: directed scenarios plus random commands vs a behavioural model.
module tb_counter_sequencer;

  localparam int W        = 5;
  localparam int PRESCALE = 4;
`ifdef CNT_SEQ_PRESCALE_EN
  localparam int P = PRESCALE;
`else
  localparam int P = 1;
`endif

  localparam logic [1:0] START = 2'b00, STOP = 2'b01, RESUME = 2'b10, ABORT = 2'b11;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'b00;
  logic [W-1:0] cmd_limit = '0;
  logic         cmd_periodic = 1'b0;
  logic [W-1:0] counter;
  logic         busy, paused, done;

  counter_sequencer #(.WIDTH(W), .PRESCALE(PRESCALE)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_limit(cmd_limit), .cmd_periodic(cmd_periodic),
    .counter(counter), .busy(busy), .paused(paused), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Behavioural model: an active run is "busy", a frozen run additionally "paused".
  int m_cnt, m_lim, m_phase;
  bit m_per, m_busy, m_paused, m_done, m_ready;
  bit last_acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit v, input logic [1:0] op,
                            input int lim, input bit per);
    bit acc;
    if (!rst) begin
      m_cnt = 0; m_lim = 0; m_per = 0; m_busy = 0; m_paused = 0;
      m_done = 0; m_ready = 0; m_phase = 0;
      return;
    end
    acc     = v && m_ready;
    m_ready = !acc;
    m_done  = 0;
    if (acc) begin
      case (op)
        START:  begin m_busy = 1; m_paused = 0; m_cnt = 0; m_lim = lim; m_per = per; m_phase = 0; end
        STOP:   if (m_busy) m_paused = 1;
        RESUME: begin m_paused = 0; m_phase = 0; end
        default: begin m_busy = 0; m_paused = 0; m_cnt = 0; m_phase = 0; end
      endcase
    end else if (m_busy && !m_paused) begin
      if (m_phase == P - 1) begin
        m_phase = 0;
        if (m_cnt == m_lim) begin
          m_done = 1;
          if (m_per) m_cnt = 0;
          else       m_busy = 0;
        end else begin
          m_cnt++;
        end
      end else begin
        m_phase++;
      end
    end
  endtask

  task automatic step(input bit rst, input bit v, input logic [1:0] op,
                      input logic [W-1:0] lim, input bit per);
    bit pre_ready;
    reset = rst; cmd_valid = v; cmd_op = op; cmd_limit = lim; cmd_periodic = per;
    pre_ready = m_ready;
    @(posedge clk);
    model_edge(rst, v, op, int'(lim), per);
    last_acc = rst && v && pre_ready;
    #1;
    check("counter",   32'(counter),   32'(m_cnt));
    check("busy",      32'(busy),      32'(m_busy));
    check("paused",    32'(paused),    32'(m_paused));
    check("done",      32'(done),      32'(m_done));
    check("cmd_ready", 32'(cmd_ready), 32'(m_ready));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 2'b00, '0, 0);
  endtask

  task automatic issue(input logic [1:0] op, input logic [W-1:0] lim, input bit per,
                       output int tries);
    tries = 0;
    do begin
      step(1, 1, op, lim, per);
      tries++;
    end while (!last_acc && tries < 4);
    check("accepted", 32'(last_acc), 32'd1);
  endtask

  initial begin
    int tries, k, ndone;
    bit pend;
    logic [1:0] r_op;
    logic [W-1:0] r_lim;
    bit r_per, r_rst;

    // Power-up reset, then reset asserted in the middle of a run.
    for (int i = 0; i < 3; i++) step(0, 0, 2'b00, '0, 0);
    idle(1);
    check("ready_after_release", 32'(cmd_ready), 32'd1);
    issue(START, 5'd20, 0, tries);
    idle(5 * P);
    check("run_count", 32'(counter), 32'd5);
    for (int i = 0; i < 3; i++) step(0, 1, START, 5'd7, 1);
    check("rst_counter", 32'(counter), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd0);
    idle(1);
    check("rst_ready_release", 32'(cmd_ready), 32'd1);

    // One-shot, limit 5.
    issue(START, 5'd5, 0, tries);
    check("oneshot_start_cnt", 32'(counter), 32'd0);
    k = 0;
    do begin idle(1); k++; end while (!done && k < 200);
    check("oneshot_done_edge", 32'(k), 32'(6 * P));
    check("oneshot_idle", 32'(busy), 32'd0);
    check("oneshot_hold", 32'(counter), 32'd5);
    idle(3);
    check("oneshot_hold_later", 32'(counter), 32'd5);

    // Periodic wrap at full-range limit: three periods.
    issue(START, 5'd31, 1, tries);
    ndone = 0;
    for (int i = 0; i < 3 * 32 * P; i++) begin idle(1); ndone += int'(done); end
    check("periodic_done_count", 32'(ndone), 32'd3);
    issue(ABORT, '0, 0, tries);
    check("abort_idle", 32'(busy), 32'd0);

    // Pause at 4 for 6 cycles, then resume.
    issue(START, 5'd10, 0, tries);
    k = 0;
    while (m_cnt != 4 && k < 200) begin idle(1); k++; end
    issue(STOP, '0, 0, tries);
    for (int i = 0; i < 6; i++) begin
      idle(1);
      check("pause_hold", 32'(counter), 32'd4);
      check("pause_flag", 32'(paused), 32'd1);
    end
    issue(RESUME, '0, 0, tries);
    check("resume_no_tick", 32'(counter), 32'd4);
    idle(P);
    check("resume_step", 32'(counter), 32'd5);
    k = P;
    do begin idle(1); k++; end while (!done && k < 200);
    check("resume_done_edge", 32'(k), 32'(7 * P));

    // ABORT colliding with the terminal tick.
    issue(START, 5'd3, 0, tries);
    k = 0;
    while (!(m_cnt == 3 && m_phase == P - 1) && k < 200) begin idle(1); k++; end
    issue(ABORT, '0, 0, tries);
    check("collide_done", 32'(done), 32'd0);
    check("collide_cnt", 32'(counter), 32'd0);
    check("collide_busy", 32'(busy), 32'd0);
    idle(1);
    check("collide_no_late_done", 32'(done), 32'd0);

    // Back-to-back command is stalled one cycle.
    issue(START, 5'd9, 1, tries);
    issue(STOP, '0, 0, tries);
    check("stall_tries", 32'(tries), 32'd2);
    check("stall_paused", 32'(paused), 32'd1);
    issue(ABORT, '0, 0, tries);

    // Limit 0 periodic.
    issue(START, 5'd0, 1, tries);
    ndone = 0;
    for (int i = 0; i < 12 * P; i++) begin
      idle(1);
      ndone += int'(done);
      check("lim0_cnt", 32'(counter), 32'd0);
    end
    check("lim0_done_count", 32'(ndone), 32'd12);
    issue(ABORT, '0, 0, tries);

    // Random commands with occasional reset; host holds a command until accepted.
    pend = 0; r_op = START; r_lim = '0; r_per = 0;
    for (int i = 0; i < 800; i++) begin
      if (!pend && $urandom_range(0, 2) == 0) begin
        pend  = 1;
        r_op  = 2'($urandom_range(0, 3));
        r_lim = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
        r_per = 1'($urandom_range(0, 1));
      end
      r_rst = ($urandom_range(0, 79) != 0);
      step(r_rst, pend, r_op, r_lim, r_per);
      if (last_acc || !r_rst) pend = 0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
